// File: rtl/receive_data_pkg.sv
// Shared definitions for the UART command/script receiver: byte tags and parser states.
package receive_data_pkg;

    localparam logic [1:0] TAG_INVALID   = 2'b00;
    localparam logic [1:0] TAG_OPERATE   = 2'b01;
    localparam logic [1:0] TAG_GAMESTATE = 2'b10;
    localparam logic [1:0] TAG_SCRIPT    = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PAYLOAD = 1'b1
    } state_e;

    function automatic logic [1:0] byte_tag(input logic [7:0] b);
        return b[1:0];
    endfunction

    function automatic logic [5:0] byte_value(input logic [7:0] b);
        return b[7:2];
    endfunction

endpackage

// File: rtl/script_fifo.sv
// Byte FIFO holding script payload; sticky overflow when a push is dropped while full.
module script_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          do_push, do_pop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;
    assign rdata    = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/receive_data.sv
// Parses tagged UART bytes into operate/game-state commands and queues script payloads.
//   state      | meaning
//   ST_IDLE    | waiting for a tagged command or script header byte
//   ST_PAYLOAD | collecting script bytes until length, 0x00 abort or timeout
module receive_data
    import receive_data_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic [7:0] data_received,
    input  logic       data_valid,
    output logic [5:0] operate_cmd,
    output logic       operate_valid,
    output logic [5:0] game_state_cmd,
    output logic [7:0] script_data,
    output logic       script_empty,
    input  logic       script_rd,
    output logic       script_overflow,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    op_cmd_q, op_cmd_d;
    logic          op_valid_q, op_valid_d;
    logic [5:0]    gs_cmd_q, gs_cmd_d;
    logic          ferr_q, ferr_d;
    logic          fifo_push;
    logic          fifo_full;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        op_cmd_d   = op_cmd_q;
        op_valid_d = 1'b0;
        gs_cmd_d   = gs_cmd_q;
        ferr_d     = 1'b0;
        fifo_push  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_valid) begin
                    case (byte_tag(data_received))
                        TAG_OPERATE: begin
                            op_cmd_d   = byte_value(data_received);
                            op_valid_d = 1'b1;
                        end
                        TAG_GAMESTATE: begin
                            gs_cmd_d = byte_value(data_received);
                        end
                        TAG_SCRIPT: begin
                            rem_d   = {1'b0, data_received[4:2]} + 4'd1;
                            tmo_d   = '0;
                            state_d = ST_PAYLOAD;
                        end
                        default: begin
                            ferr_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (data_valid) begin
                    if (data_received == 8'h00) begin
                        ferr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // Length counts every byte offered, even ones the FIFO drops.
                        fifo_push = 1'b1;
                        rem_d     = rem_q - 4'd1;
                        tmo_d     = '0;
                        if (rem_q == 4'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    ferr_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            tmo_q      <= '0;
            op_cmd_q   <= '0;
            op_valid_q <= 1'b0;
            gs_cmd_q   <= '0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            op_cmd_q   <= op_cmd_d;
            op_valid_q <= op_valid_d;
            gs_cmd_q   <= gs_cmd_d;
            ferr_q     <= ferr_d;
        end
    end

    script_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_script_fifo (
        .clk     (uart_clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wdata   (data_received),
        .pop     (script_rd),
        .rdata   (script_data),
        .full    (fifo_full),
        .empty   (script_empty),
        .overflow(script_overflow)
    );

    assign operate_cmd    = op_cmd_q;
    assign operate_valid  = op_valid_q;
    assign game_state_cmd = gs_cmd_q;
    assign frame_error    = ferr_q;

endmodule

// File: doc/receive_data.md
RECEIVE_DATA -- requirements
Module: receive_data

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: script FIFO depth in bytes, power of two.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: maximum uart_clk cycles allowed between consecutive payload bytes.
REQ-003 Port uart_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port data_received, input, 8: byte from the UART receiver.
REQ-006 Port data_valid, input, 1: one-cycle strobe; data_received is valid this cycle.
REQ-007 Port operate_cmd, output, 6: last decoded operate code.
REQ-008 Port operate_valid, output, 1: one-cycle pulse when operate_cmd updates.
REQ-009 Port game_state_cmd, output, 6: last decoded game-state request, held until replaced.
REQ-010 Port script_data, output, 8: FIFO head byte, valid while script_empty=0.
REQ-011 Port script_empty, output, 1: FIFO empty.
REQ-012 Port script_rd, input, 1: pop FIFO head this cycle.
REQ-013 Port script_overflow, output, 1: sticky flag; a payload byte was dropped.
REQ-014 Port frame_error, output, 1: one-cycle pulse on a protocol error.

Function
REQ-015 Byte tags are data_received[1:0]; the value field is data_received[7:2].
- 2'b01 = OPERATE
- 2'b10 = GAMESTATE
- 2'b11 = SCRIPT header
- 2'b00 = invalid
REQ-016 The FSM has two states, IDLE and PAYLOAD; reset enters IDLE.
REQ-017 In IDLE, a valid OPERATE byte loads operate_cmd=[7:2] and pulses operate_valid on the next cycle; latency is 1 cycle.
REQ-018 In IDLE, a valid GAMESTATE byte loads game_state_cmd=[7:2] on the next cycle; there is no pulse.
REQ-019 In IDLE, a valid SCRIPT byte sets remaining=[4:2]+1 (range 1..8), clears the timeout counter, and enters PAYLOAD; bits [7:5] are ignored.
REQ-020 In IDLE, a valid byte with tag 2'b00 (including 0x00) pulses frame_error and the FSM stays in IDLE.
REQ-021 In PAYLOAD, each valid byte of any value other than 0x00 is pushed to the FIFO, decrements remaining, and clears the timeout counter; on remaining reaching 0 the FSM returns to IDLE.
REQ-022 In PAYLOAD, a 0x00 byte aborts the frame: frame_error pulses, the FSM goes to IDLE, and nothing is pushed.
REQ-023 In PAYLOAD, the timeout counter increments on every cycle without data_valid; reaching TIMEOUT_CYCLES pulses frame_error and returns to IDLE. Bytes already pushed remain in the FIFO.
REQ-024 The FIFO read/write rules are:
- Push and pop take effect at the clock edge.
- script_data shows the head byte combinationally from the registered storage.
- Pointers wrap modulo FIFO_DEPTH.
REQ-025 Push while full with no pop drops the byte and sets script_overflow; remaining still decrements.
REQ-026 Push and pop in the same cycle, whether full or not, both occur and the occupancy is unchanged.
REQ-027 script_rd while empty is ignored.
REQ-028 script_overflow clears only on reset.
REQ-029 OPERATE and GAMESTATE bytes arriving in PAYLOAD are treated as payload data, not decoded.

Reset
REQ-030 While rst_n=0 at a clock edge, the following reset values apply:
- operate_cmd=0, operate_valid=0, game_state_cmd=0
- script_empty=1, script_overflow=0, frame_error=0
- FIFO pointers and count=0, FSM=IDLE, counters=0
REQ-031 Reset asserted mid-frame discards the partial frame and all FIFO contents; data_valid is ignored during reset.

Structure
REQ-032 Shared package receive_data_pkg holds the tag constants TAG_OPERATE, TAG_GAMESTATE and TAG_SCRIPT, plus the FSM state encoding.
REQ-033 The FIFO is a sub-module named script_fifo, parameterised by depth and providing full/empty/overflow; the parser FSM stays in receive_data.

Verification
REQ-034 Send 0x0D (tag 01, value 3) -> operate_valid pulses once on the next cycle with operate_cmd=3; game_state_cmd stays 0.
REQ-035 Send 0x0B (SCRIPT, length 3), then 0x41, 0x42, 0x43 -> FSM back in IDLE; popping in order yields 0x41, 0x42, 0x43; script_empty=1 after the third pop.
REQ-036 Send 0x1F (length 8) and 8 payload bytes; then 0x1F and 8 more bytes with no reads -> the FIFO holds the first 8 bytes, script_overflow=1, and the FSM is in IDLE.
REQ-037 Send 0x07 (length 2), then one byte, then idle for TIMEOUT_CYCLES -> frame_error pulses once, the FIFO holds 1 byte, and a following 0x0D decodes as OPERATE.
REQ-038 Send 0x00 in IDLE and in PAYLOAD -> frame_error pulses each time; in PAYLOAD the FSM aborts to IDLE with nothing pushed.
REQ-039 Assert rst_n=0 mid-payload with a non-empty FIFO -> all outputs return to reset values on the next edge.
